// File: rtl/multu_hilo_unit_pkg.sv
// Shared constants for the HI/LO multiplier: funct codes, FSM encoding, default width.
package multu_hilo_unit_pkg;

  localparam int unsigned FUNCT_W       = 6;
  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam logic [FUNCT_W-1:0] MULTU = 6'b011001;
  localparam logic [FUNCT_W-1:0] MULT  = 6'b011000;
  localparam logic [FUNCT_W-1:0] MFHI  = 6'b010000;
  localparam logic [FUNCT_W-1:0] MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // MULT only counts as a start code when the signed option is built in
  function automatic logic is_start_code(input logic [FUNCT_W-1:0] code, input logic signed_en);
    return (code == MULTU) || (signed_en && (code == MULT));
  endfunction

endpackage

// File: rtl/multu_hilo_unit_mult_step.sv
// One shift-add iteration on the {carry, upper, lower} product register.
module mult_step
  import multu_hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH:0] prod,
  input  logic [WIDTH-1:0] a,
  output logic [2*WIDTH:0] prod_nxt_c
);

  logic [WIDTH:0] upper_sum;

  always_comb begin
    upper_sum = prod[2*WIDTH:WIDTH];
    if (prod[0]) begin
      upper_sum = prod[2*WIDTH:WIDTH] + {1'b0, a};
    end
    prod_nxt_c = {1'b0, upper_sum, prod[WIDTH-1:1]};
  end

endmodule

// File: rtl/multu_hilo_unit.sv
// Sequential shift-add multiplier with HI/LO registers and MFHI/MFLO read port.
// Optional signed MULT support is compiled in with `define MULT_SIGNED_EN.
module multu_hilo_unit
  import multu_hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         ctrl,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [WIDTH-1:0]   dataOut,
  output logic               busy,
  output logic               done
);

  localparam int unsigned PW    = 2 * WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(WIDTH);

`ifdef MULT_SIGNED_EN
  localparam logic SIGNED_EN = 1'b1;
`else
  localparam logic SIGNED_EN = 1'b0;
`endif

  state_e             state, state_nxt;
  logic [PW-1:0]      prod;
  logic [PW-1:0]      prod_step_c;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   a_load_c;
  logic [WIDTH-1:0]   b_load_c;
  logic [2*WIDTH-1:0] result_c;
  logic [CNT_W-1:0]   cnt;
  logic               prev_multu;
  logic               start_code_c;
  logic               start_c;
  logic               last_c;

  assign start_code_c = is_start_code(ctrl, SIGNED_EN);

`ifdef MULT_SIGNED_EN
  logic sign_q;
  logic is_mult_c;

  // MULT runs the unsigned core on magnitudes and fixes the sign on writeback
  assign is_mult_c = (ctrl == MULT);
  assign a_load_c  = (is_mult_c && dataA[WIDTH-1]) ? -dataA : dataA;
  assign b_load_c  = (is_mult_c && dataB[WIDTH-1]) ? -dataB : dataB;
  assign result_c  = sign_q ? -prod_step_c[2*WIDTH-1:0] : prod_step_c[2*WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
    end else if (start_c) begin
      sign_q <= is_mult_c && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
    end
  end
`else
  assign a_load_c = dataA;
  assign b_load_c = dataB;
  assign result_c = prod_step_c[2*WIDTH-1:0];
`endif

  mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .prod       (prod),
    .a          (a_q),
    .prod_nxt_c (prod_step_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Start only on a fresh start code while idle; last iteration ends RUN
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    last_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start_code_c && !prev_multu) begin
          start_c   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last_c    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod       <= '0;
      a_q        <= '0;
      cnt        <= '0;
      prev_multu <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      prev_multu <= start_code_c;
      busy       <= (state_nxt != IDLE);
      done       <= (state_nxt == DONE);
      if (start_c) begin
        prod <= {(WIDTH + 1)'(0), b_load_c};
        a_q  <= a_load_c;
        cnt  <= '0;
      end else if (state == RUN) begin
        prod <= prod_step_c;
        cnt  <= cnt + CNT_W'(1);
      end
      if (last_c) begin
        hi <= result_c[2*WIDTH-1:WIDTH];
        lo <= result_c[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    dataOut = lo;
    case (ctrl)
      MFHI:    dataOut = hi;
      MFLO:    dataOut = lo;
      default: dataOut = lo;
    endcase
  end

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Self-checking bench for multu_hilo_unit: vector table, random operands, multi-cycle corner cases.
module tb_multu_hilo_unit;

  localparam int unsigned W = 32;
  localparam logic [5:0] C_MULTU = 6'b011001;
  localparam logic [5:0] C_MULT  = 6'b011000;
  localparam logic [5:0] C_MFHI  = 6'b010000;
  localparam logic [5:0] C_MFLO  = 6'b010010;
  localparam logic [5:0] C_ADD   = 6'b100000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [5:0]   ctrl;
  logic [W-1:0] dataA, dataB;
  logic [W-1:0] hi, lo, dataOut;
  logic         busy, done;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_hilo = '0;

  always #5 clk = ~clk;

  multu_hilo_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl    (ctrl),
    .dataA   (dataA),
    .dataB   (dataB),
    .hi      (hi),
    .lo      (lo),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return 64'(a) * 64'(b);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 100 && busy; c++) @(posedge clk);
    #1;
    if (busy) chk("idle_timeout", 64'(busy), 64'(0));
  endtask

  // Pulse a start code for one edge, then wait (bounded) for done
  task automatic do_mul(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    wait_idle();
    @(negedge clk);
    ctrl = code; dataA = a; dataB = b;
    @(posedge clk); #1;
    ctrl = C_ADD;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic mul_check(input string name, input logic [5:0] code, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
    int lat;
    do_mul(code, a, b, lat);
    chk({name, "_latency"}, 64'(lat), 64'(W));
    chk({name, "_hilo"}, {hi, lo}, exp);
    exp_hilo = exp;
    @(posedge clk); #1;
    chk({name, "_done_one_cycle"}, 64'(done), 64'(0));
    chk({name, "_busy_low"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int lat;
    int pulses;
    int seen;
    logic [31:0] ra, rb;

    tbl[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    tbl[1] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
    tbl[2] = '{32'd6,         32'd7,         64'd42};
    tbl[3] = '{32'd0,         32'd12345,     64'd0};
    tbl[4] = '{32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000};
    tbl[5] = '{32'd3,         32'd5,         64'd15};

    rst_n = 1'b0; ctrl = C_ADD; dataA = '0; dataB = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", 64'(hi), 64'(0));
    chk("reset_lo", 64'(lo), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      mul_check($sformatf("vec%0d", i), C_MULTU, tbl[i].a, tbl[i].b, tbl[i].prod);

    // Read port after 0x10000 * 0x10000
    mul_check("rdport_mul", C_MULTU, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    @(negedge clk) ctrl = C_MFHI;
    #1 chk("mfhi", 64'(dataOut), 64'h1);
    @(negedge clk) ctrl = C_MFLO;
    #1 chk("mflo", 64'(dataOut), 64'h0);
    @(negedge clk) ctrl = C_ADD;

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      mul_check($sformatf("rand%0d", i), C_MULTU, ra, rb, model(ra, rb, 1'b0));
    end

    // Held MULTU: one product, operands sampled only at start
    wait_idle();
    @(negedge clk);
    ctrl = C_MULTU; dataA = 32'd6; dataB = 32'd7;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (c == 3) dataB = 32'd100;
      if (done) pulses++;
    end
    @(negedge clk) ctrl = C_ADD;
    chk("held_pulses", 64'(pulses), 64'(1));
    chk("held_hilo", {hi, lo}, 64'd42);
    exp_hilo = 64'd42;

    // MULTU while busy is ignored; MFHI while busy reads stale HI
    wait_idle();
    @(negedge clk);
    ctrl = C_MULTU; dataA = 32'd11; dataB = 32'd13;
    @(posedge clk);
    @(negedge clk) ctrl = C_MFHI;
    #1 chk("stale_mfhi", 64'(dataOut), 64'(exp_hilo[63:32]));
    repeat (3) @(posedge clk);
    @(negedge clk) ctrl = C_ADD;
    @(posedge clk);
    @(negedge clk) begin ctrl = C_MULTU; dataA = 32'd2; dataB = 32'd2; end
    @(posedge clk);
    @(negedge clk) ctrl = C_ADD;
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    chk("busy_ignore_done", 64'(seen), 64'(1));
    chk("busy_ignore_hilo", {hi, lo}, 64'd143);
    mul_check("after_busy", C_MULTU, 32'd3, 32'd4, 64'd12);

    // Asynchronous reset in the middle of a run
    wait_idle();
    @(negedge clk);
    ctrl = C_MULTU; dataA = 32'd7; dataB = 32'd9;
    @(posedge clk);
    @(negedge clk) ctrl = C_ADD;
    repeat (9) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst_hi", 64'(hi), 64'(0));
    chk("midrst_lo", 64'(lo), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    exp_hilo = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mul_check("post_rst", C_MULTU, 32'd3, 32'd5, 64'd15);

`ifdef MULT_SIGNED_EN
    mul_check("mult_neg", C_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      mul_check($sformatf("srand%0d", i), C_MULT, ra, rb, model(ra, rb, 1'b1));
    end
    mul_check("multu_unsigned", C_MULTU, 32'hFFFF_FFFD, 32'd5, model(32'hFFFF_FFFD, 32'd5, 1'b0));
`else
    wait_idle();
    @(negedge clk);
    ctrl = C_MULT; dataA = 32'hFFFF_FFFD; dataB = 32'd5;
    @(posedge clk);
    @(negedge clk) ctrl = C_ADD;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (busy || done) seen++;
    end
    chk("mult_noop_activity", 64'(seen), 64'(0));
    chk("mult_noop_hilo", {hi, lo}, exp_hilo);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multu_hilo_unit.md
Name: multu_hilo_unit

Overview:
- Sequential shift-add unsigned multiplier with HI/LO result registers.
- Consumes the 6-bit multiplier control code issued by the ALU control decoder: MULTU starts a multiply; MFHI/MFLO select which result register drives the read port.
- Sits beside the ALU and shifter; its read port feeds the datapath result MUX.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- ctrl  input  6  multiplier control code (MULTU=6'b011001, MFHI=6'b010000, MFLO=6'b010010; others = no-op)
- dataA  input  WIDTH  multiplicand
- dataB  input  WIDTH  multiplier
- hi  output  WIDTH  HI register (upper product half)
- lo  output  WIDTH  LO register (lower product half)
- dataOut  output  WIDTH  combinational: hi when ctrl==MFHI, lo otherwise
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle pulse; HI/LO hold the new product

Behaviour:
- Reset (rst_n low, any time, including mid-operation):
  - state=IDLE; hi=0, lo=0, done=0, busy=0.
  - Product register and counter cleared; no partial result survives.
- Start detection:
  - prev_multu flop records (ctrl==MULTU) each cycle; reset value 0.
  - start = (ctrl==MULTU) && !prev_multu && state==IDLE.
  - A MULTU held for several cycles starts exactly one multiply. Re-issue requires ctrl to leave MULTU first.
- MULTU while busy: ignored; no restart, no queueing.
- States:
  - IDLE: on start, load prod={WIDTH+1 zero bits, dataB} (carry bit + upper half + lower half), latch A=dataA, cnt=0, go to RUN.
  - RUN: each cycle, if prod[0], upper WIDTH+1 bits += A (zero-extended); then shift prod right 1; cnt++. Operands are sampled only at start; later changes to dataA/dataB have no effect.
  - RUN, on the cycle where cnt==WIDTH-1 completes: write hi=final prod[2W-1:W] and lo=final prod[W-1:0] on that edge, go to DONE.
  - DONE: done=1 for exactly one cycle; unconditional return to IDLE.
- Latency:
  - Start sampled at edge 0; HI/LO updated at edge WIDTH; done high for the cycle after edge WIDTH.
  - Next start accepted at edge WIDTH+1 at earliest.
- Arithmetic: unsigned; product exact over 2*WIDTH bits; no overflow is possible.
- MFHI/MFLO while busy: dataOut returns the previous (stale) HI/LO. Stalling is the pipeline's job via busy.
- hi/lo change only on the completing edge or on reset.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- Defined:
  - ctrl==6'b011000 (MULT) is also a start code, with the same edge detection as MULTU.
  - At start, operands are converted to magnitudes and sign = A[W-1]^B[W-1] is latched.
  - At completion, the 2*WIDTH product is two's-complement negated before the HI/LO write when sign=1.
  - Latency is unchanged.
- Undefined: 6'b011000 is a no-op; no sign logic is synthesised.

Decomposition:
- Shared package holds:
  - funct constants MULTU, MULT, MFHI, MFLO;
  - state encoding IDLE/RUN/DONE (2 bits);
  - default WIDTH.
- One sub-module, mult_step: combinational single iteration (conditional add plus right shift on the 2*WIDTH+1-bit product). The top module owns the FSM, counter, edge detect and HI/LO.

Test Plan:
- Reset mid-run: issue MULTU 7*9, assert rst_n low at edge 10 → hi=0, lo=0, busy=0 immediately. After release, a new MULTU 3*5 yields lo=15.
- MULTU dataA=0xFFFFFFFF, dataB=0xFFFFFFFF → at edge 32: hi=0xFFFFFFFE, lo=0x00000001; done pulse in the next cycle; busy low after edge 33.
- MULTU 0x00010000*0x00010000, then ctrl=MFHI → dataOut=0x00000001; ctrl=MFLO → dataOut=0x00000000.
- ctrl held at MULTU for 40 cycles, dataA=6, dataB=7 → exactly one done pulse; lo=42, hi=0. dataB changed to 100 during RUN → result still 42.
- Second MULTU pulse at edge 5 during busy → ignored; result is the first product. A MULTU at edge 33 after ctrl returned to ADD is accepted.
- With MULT_SIGNED_EN: MULT dataA=0xFFFFFFFD(-3), dataB=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Without the macro, the same stimulus produces no busy and no done.
